ysyx_22040127_fetch: RTL
========================

# ysyx_22040127_fetch

Instruction fetch stage: owns the PC, issues one instruction-cache request at a time, and buffers the returned instruction until decode accepts it. It sits directly upstream of decode and drives decode's `if_to_id_valid`/`if_to_id_bus` handshake. It applies redirects from decode (taken branch/jal/jalr) and from the trap path (ecall→mtvec, mret→mepc), discarding any wrong-path instruction already in flight.

## Interface
- `RESET_PC`, default 32'h8000_0000: first fetch address after reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `id_allowin` in 1: decode can accept this cycle.
- `if_to_id_valid` out 1: held instruction valid for decode.
- `if_to_id_bus` out 65: {ebreak[64], inst[63:32], pc[31:0]}.
- `id_redirect` in 1: decode resolved a taken control transfer this cycle (pre-qualified by decode valid).
- `id_redirect_pc` in 32: target for `id_redirect`.
- `trap_redirect` in 1: trap/mret redirect from writeback.
- `trap_pc` in 32: target for `trap_redirect`.
- `icache_req` out 1: request valid.
- `icache_addr` out 32: request address (current PC).
- `icache_addr_ok` in 1: cache accepts request this cycle.
- `icache_rsp_valid` in 1: response data valid (one per accepted request, ≥1 cycle after accept).
- `icache_rsp_data` in 32: instruction word.
- `preif_allowin` out 1: `icache_req & icache_addr_ok` (request handshake this cycle).

## Operation
- States: BOOT, REQ, WAIT, CANCEL, HOLD. Registers: `pc`, `redir_pc`, `inst_buf`.
- BOOT: reset state; → REQ next cycle. `icache_req`=0.
- REQ: `icache_req`=1, `icache_addr`=`pc`. On `icache_addr_ok` → WAIT.
- WAIT: on `icache_rsp_valid` capture data into `inst_buf` → HOLD.
- HOLD: `if_to_id_valid`=1. On `id_allowin`: `pc` ← `pc`+4 (mod 2^32) → REQ.
- CANCEL: waiting to drop one outstanding response; on `icache_rsp_valid` discard it, `pc` ← `redir_pc` → REQ.
- Redirect = `trap_redirect` | `id_redirect`; target = `trap_pc` if `trap_redirect`, else `id_redirect_pc`; target[1:0] forced to 0.
- Redirect by state: BOOT/REQ → `pc` ← target, stay/enter REQ (address not yet accepted, so no cancel needed, even if `icache_addr_ok` is high the same cycle → go to CANCEL instead, `redir_pc` ← target). WAIT without `icache_rsp_valid` → CANCEL, `redir_pc` ← target. WAIT with `icache_rsp_valid` → drop data, `pc` ← target → REQ. HOLD → drop `inst_buf` regardless of `id_allowin`, `pc` ← target → REQ. CANCEL → `redir_pc` ← target (latest wins), still drops the pending response.
- `ebreak` bit = (`inst_buf` == 32'h0010_0073).
- `if_to_id_bus` = {ebreak, `inst_buf`, `pc`}; stable while HOLD and not accepted.

## Timing
- Reset values: state BOOT, `pc`=RESET_PC, `inst_buf`=0; `if_to_id_valid`=0, `if_to_id_bus`=0, `icache_req`=0, `preif_allowin`=0.
- Reset mid-operation: state forced to BOOT; an in-flight cache response after reset is ignored (BOOT/REQ ignore `icache_rsp_valid`).
- Minimum loop with 1-cycle cache: REQ(accept) → WAIT(rsp) → HOLD(accept) = 3 cycles/instruction.
- `if_to_id_valid` is a pure function of state (no combinational path from `id_allowin` or redirects).
- `icache_req`/`icache_addr` held stable from REQ entry until `icache_addr_ok`, except on redirect.
- At most one outstanding cache request at any time.

## Structure
- Shared package `ysyx_22040127_pkg`: fetch state enum, `IF_TO_ID_WIDTH`=65, `INST_EBREAK`=32'h0010_0073, `RESET_PC` default.
- One natural sub-module: `ysyx_22040127_npc` (redirect priority/target selection and pc+4); the FSM and buffer stay in the top.

## Test plan
- Reset release, cache accepts immediately, responds next cycle with 32'h0000_0013, `id_allowin`=1 → bus = {0, 32'h0000_0013, 32'h8000_0000} valid in cycle 3; next request address 32'h8000_0004.
- `id_allowin`=0 for 5 cycles in HOLD → valid held, bus unchanged, no new `icache_req`.
- `id_redirect` to 32'h8000_0100 while in WAIT, response arrives 3 cycles later → response discarded, next `icache_addr`=32'h8000_0100, never presented to decode.
- `trap_redirect`(32'h8000_0200) and `id_redirect`(32'h8000_0300) same cycle in HOLD → next request at 32'h8000_0200, held instruction dropped.
- Fetch returns 32'h0010_0073 → bus bit 64 = 1; any other word → 0.
- Assert reset while in WAIT, cache response arrives during BOOT → ignored; first request after reset at RESET_PC.

Source files
------------

// File: rtl/ysyx_22040127_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the fetch top and its helpers.
package ysyx_22040127_pkg;

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_CANCEL,
    S_HOLD
  } fetch_state_t;

  localparam int IF_TO_ID_WIDTH = 65;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  function automatic logic is_ebreak(
    input logic [31:0] inst
  );
    return inst == INST_EBREAK;
  endfunction

endpackage

// File: rtl/ysyx_22040127_npc.sv
// Next-pc selection: redirect priority, target
// alignment and the sequential pc+4 path.
module ysyx_22040127_npc (
  input  logic [31:0] pc,
  input  logic        id_redirect,
  input  logic [31:0] id_redirect_pc,
  input  logic        trap_redirect,
  input  logic [31:0] trap_pc,
  output logic        redirect,
  output logic [31:0] target,
  output logic [31:0] seq_pc
);

  logic [31:0] sel;

  assign redirect = trap_redirect | id_redirect;
  // trap path outranks decode's branch target
  assign sel = trap_redirect ? trap_pc : id_redirect_pc;
  assign target = {sel[31:2], 2'b00};
  assign seq_pc = pc + 32'd4;

endmodule

// File: rtl/ysyx_22040127_fetch.sv
// Instruction fetch stage: pc owner, single
// outstanding icache request, one-entry buffer.
module ysyx_22040127_fetch
  import ysyx_22040127_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_allowin,
  output logic        if_to_id_valid,
  output logic [IF_TO_ID_WIDTH-1:0] if_to_id_bus,
  input  logic        id_redirect,
  input  logic [31:0] id_redirect_pc,
  input  logic        trap_redirect,
  input  logic [31:0] trap_pc,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_addr_ok,
  input  logic        icache_rsp_valid,
  input  logic [31:0] icache_rsp_data,
  output logic        preif_allowin
);

  fetch_state_t state;
  logic [31:0] pc;
  logic [31:0] redir_pc;
  logic [31:0] inst_buf;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] seq_pc;

  ysyx_22040127_npc u_npc (
    .pc             (pc),
    .id_redirect    (id_redirect),
    .id_redirect_pc (id_redirect_pc),
    .trap_redirect  (trap_redirect),
    .trap_pc        (trap_pc),
    .redirect       (redirect),
    .target         (target),
    .seq_pc         (seq_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_BOOT;
      pc       <= RESET_PC;
      redir_pc <= RESET_PC;
      inst_buf <= '0;
    end else begin
      unique case (state)
        S_BOOT: begin
          state <= S_REQ;
          if (redirect) pc <= target;
        end
        S_REQ: begin
          if (redirect) begin
            // accepted same cycle: its reply must be dropped
            if (icache_addr_ok) begin
              redir_pc <= target;
              state    <= S_CANCEL;
            end else begin
              pc <= target;
            end
          end else if (icache_addr_ok) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            if (icache_rsp_valid) begin
              pc    <= target;
              state <= S_REQ;
            end else begin
              redir_pc <= target;
              state    <= S_CANCEL;
            end
          end else if (icache_rsp_valid) begin
            inst_buf <= icache_rsp_data;
            state    <= S_HOLD;
          end
        end
        S_CANCEL: begin
          if (icache_rsp_valid) begin
            pc    <= redirect ? target : redir_pc;
            state <= S_REQ;
          end else if (redirect) begin
            redir_pc <= target;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= S_REQ;
          end else if (id_allowin) begin
            pc    <= seq_pc;
            state <= S_REQ;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

  assign if_to_id_valid = (state == S_HOLD);
  assign icache_req     = (state == S_REQ);
  assign icache_addr    = pc;
  assign preif_allowin  = icache_req & icache_addr_ok;

  assign if_to_id_bus = if_to_id_valid
    ? {is_ebreak(inst_buf), inst_buf, pc}
    : '0;

endmodule
